hlsm_branch_unit: RTL and testbench
===================================

HLSM_BRANCH_UNIT -- requirements
Module: hlsm_branch_unit

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, giving the signed operand/result width (legal range 8..64).
REQ-002 SHALL have parameter SHW, default $clog2(DATAWIDTH), giving the shift-amount width taken from k.
REQ-003 Clk  input  1  clock; all state updates on the rising edge.
REQ-004 Rst  input  1  reset; synchronous, active-high.
REQ-005 Start  input  1  request; sampled only in state Wait.
REQ-006 mode  input  2  outer-compare select: 0=GT, 1=LT, 2=EQ, 3=GE.
REQ-007 a, b, c, k  input  DATAWIDTH each  signed operands; k is both the addend and the shift source.
REQ-008 Busy  output  1  high in every state except Wait.
REQ-009 Done  output  1  registered one-cycle completion pulse.
REQ-010 x, y, z  output  DATAWIDTH each  signed registered results.

Function
REQ-011 SHALL latch a, b, c, k and mode into internal registers on the edge where State=Wait and Start=1; later input changes SHALL NOT affect the run.
REQ-012 SHALL sequence Wait->S0->S1->S2->S3->S4->S5->Final->Wait, one state per cycle, with no stalls.
REQ-013 S0: d<=a+b, e<=a+c.
REQ-014 S1: f<=a-b; outer<=cmp_mode(d,e); inner<=(d>e), signed compares.
REQ-015 S2: resolve branch: outer&inner -> g=e+k, h=f+k; outer&!inner -> g=d+e, h=f+e; !outer -> g=d, h=f; register g, h.
REQ-016 S3: y<=g.
REQ-017 S4: x<=h<<k[SHW-1:0], logical left shift truncated to DATAWIDTH.
REQ-018 S5: z<=h>>>k[SHW-1:0], arithmetic right shift with sign fill.
REQ-019 Final: Done<=1, State<=Wait; Done SHALL be 0 in every other cycle.
REQ-020 Latency: Done SHALL be high in the cycle beginning 8 edges after the edge that sampled Start.
REQ-021 Start while Busy=1 SHALL be ignored; no queuing.
REQ-022 Start=1 in the cycle Done=1 (State=Wait) SHALL start a new run; Done drops on that edge.
REQ-023 x, y, z SHALL hold their values between runs until overwritten.
REQ-024 Without saturation, all add/sub results SHALL wrap modulo 2^DATAWIDTH.

Reset
REQ-025 Rst=1 SHALL force State=Wait, Done=0, x=y=z=0 and clear internal d..h, outer and inner, overriding all other activity.
REQ-026 Rst asserted mid-run SHALL abort the run; no Done pulse SHALL follow, and Start is accepted on the first edge with Rst=0.

Configuration
REQ-027 Macro HLSM_BRANCH_SAT_EN defined: every add/sub (d, e, f, g, h) SHALL saturate to [-2^(W-1), 2^(W-1)-1].
REQ-028 Macro HLSM_BRANCH_SAT_EN undefined: arithmetic SHALL wrap per REQ-024; latency is unchanged in both builds.

Verification (DATAWIDTH=32)
REQ-029 a=5, b=3, c=1, k=1, mode=GT -> y=7, x=6, z=1; Done pulses once, 8 edges after Start.
REQ-030 Same operands, mode=EQ -> y=8, x=4, z=1.
REQ-031 a=4, b=2, c=2, k=2, mode=GE -> y=12, x=32, z=2.
REQ-032 a=-8, b=-8, c=0, k=1, mode=LT -> y=-24, x=-16, z=-4.
REQ-033 a=0x7FFFFFFF, b=1, c=0, k=0, mode=GT -> y=0x7FFFFFFF with SAT_EN, 0x80000000 without; x=z=0x7FFFFFFE in both builds.
REQ-034 Rst pulsed in S3, then Start re-pulsed -> no Done from the aborted run; outputs read 0 after Rst; the new run completes per REQ-020; Start pulses during Busy are ignored.

Source files
------------

// File: rtl/hlsm_branch_unit.sv
// Eight-state branch datapath: latches a,b,c,k,mode on Start, publishes x,y,z and a one-cycle Done 8 edges later (sampling edge included).
// Start is ignored while Busy, with no queuing; define HLSM_BRANCH_SAT_EN to saturate every add/sub instead of wrapping.
module hlsm_branch_unit #(
    parameter int DATAWIDTH = 32,
    parameter int SHW       = $clog2(DATAWIDTH)
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        Start,
    input  logic [1:0]                  mode,
    input  logic signed [DATAWIDTH-1:0] a,
    input  logic signed [DATAWIDTH-1:0] b,
    input  logic signed [DATAWIDTH-1:0] c,
    input  logic signed [DATAWIDTH-1:0] k,
    output logic                        Busy,
    output logic                        Done,
    output logic signed [DATAWIDTH-1:0] x,
    output logic signed [DATAWIDTH-1:0] y,
    output logic signed [DATAWIDTH-1:0] z
);

    typedef enum logic [2:0] {
        ST_WAIT, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_FINAL
    } state_t;

    state_t state, state_nxt;

    logic signed [DATAWIDTH-1:0] a_r, b_r, c_r, k_r;
    logic [1:0]                  mode_r;
    logic signed [DATAWIDTH-1:0] d, e, f, g, h;
    logic                        outer, inner;
    logic                        outer_nxt;

`ifdef HLSM_BRANCH_SAT_EN
    localparam logic signed [DATAWIDTH-1:0] SMAX = {1'b0, {(DATAWIDTH-1){1'b1}}};
    localparam logic signed [DATAWIDTH-1:0] SMIN = {1'b1, {(DATAWIDTH-1){1'b0}}};

    // One guard bit: overflow when the two top bits of the widened result differ.
    function automatic logic signed [DATAWIDTH-1:0] arith(
        input logic signed [DATAWIDTH-1:0] p,
        input logic signed [DATAWIDTH-1:0] q,
        input logic                        sub
    );
        logic signed [DATAWIDTH:0] r;
        r = sub ? ({p[DATAWIDTH-1], p} - {q[DATAWIDTH-1], q})
                : ({p[DATAWIDTH-1], p} + {q[DATAWIDTH-1], q});
        if (r[DATAWIDTH] != r[DATAWIDTH-1])
            arith = r[DATAWIDTH] ? SMIN : SMAX;
        else
            arith = r[DATAWIDTH-1:0];
    endfunction
`else
    function automatic logic signed [DATAWIDTH-1:0] arith(
        input logic signed [DATAWIDTH-1:0] p,
        input logic signed [DATAWIDTH-1:0] q,
        input logic                        sub
    );
        arith = sub ? (p - q) : (p + q);
    endfunction
`endif

    always_ff @(posedge Clk) begin
        if (Rst)
            state <= ST_WAIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Busy      = (state != ST_WAIT);
        case (state)
            ST_WAIT:  if (Start) state_nxt = ST_S0;
            ST_S0:    state_nxt = ST_S1;
            ST_S1:    state_nxt = ST_S2;
            ST_S2:    state_nxt = ST_S3;
            ST_S3:    state_nxt = ST_S4;
            ST_S4:    state_nxt = ST_S5;
            ST_S5:    state_nxt = ST_FINAL;
            ST_FINAL: state_nxt = ST_WAIT;
            default:  state_nxt = ST_WAIT;
        endcase
    end

    always_comb begin
        outer_nxt = 1'b0;
        case (mode_r)
            2'd0:    outer_nxt = (d >  e);
            2'd1:    outer_nxt = (d <  e);
            2'd2:    outer_nxt = (d == e);
            default: outer_nxt = (d >= e);
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Done   <= 1'b0;
            x      <= '0;
            y      <= '0;
            z      <= '0;
            d      <= '0;
            e      <= '0;
            f      <= '0;
            g      <= '0;
            h      <= '0;
            outer  <= 1'b0;
            inner  <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            c_r    <= '0;
            k_r    <= '0;
            mode_r <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_WAIT: if (Start) begin
                    a_r    <= a;
                    b_r    <= b;
                    c_r    <= c;
                    k_r    <= k;
                    mode_r <= mode;
                end
                ST_S0: begin
                    d <= arith(a_r, b_r, 1'b0);
                    e <= arith(a_r, c_r, 1'b0);
                end
                ST_S1: begin
                    f     <= arith(a_r, b_r, 1'b1);
                    outer <= outer_nxt;
                    inner <= (d > e);
                end
                ST_S2: begin
                    if (outer && inner) begin
                        g <= arith(e, k_r, 1'b0);
                        h <= arith(f, k_r, 1'b0);
                    end else if (outer) begin
                        g <= arith(d, e, 1'b0);
                        h <= arith(f, e, 1'b0);
                    end else begin
                        g <= d;
                        h <= f;
                    end
                end
                ST_S3:    y <= g;
                ST_S4:    x <= h << k_r[SHW-1:0];
                ST_S5:    z <= h >>> k_r[SHW-1:0];
                ST_FINAL: Done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hlsm_branch_unit.sv
// Directed bench for hlsm_branch_unit: operand table plus back-to-back, hold, busy-Start and mid-run reset sequences.
module tb_hlsm_branch_unit;
    localparam int W = 32;

    logic                Clk = 1'b0;
    logic                Rst;
    logic                Start;
    logic [1:0]          mode;
    logic signed [W-1:0] a, b, c, k;
    logic                Busy, Done;
    logic signed [W-1:0] x, y, z;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] a, b, c, k;
        logic [1:0]   mode;
        logic [W-1:0] ex, ey, ez;
    } vec_t;

    vec_t vecs[8];

    hlsm_branch_unit #(.DATAWIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .mode(mode),
        .a(a), .b(b), .c(c), .k(k),
        .Busy(Busy), .Done(Done), .x(x), .y(y), .z(z)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [W-1:0] a_, b_, c_, k_, input logic [1:0] m,
                                input logic [W-1:0] ex_, ey_, ez_);
        vec_t v;
        v.a = a_; v.b = b_; v.c = c_; v.k = k_; v.mode = m;
        v.ex = ex_; v.ey = ey_; v.ez = ez_;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic scramble();
        a = 32'sh1234_5678; b = -99; c = 77; k = 3; mode = 2'd1;
    endtask

    // Drives Start off-edge; returns #1 after the edge that sampled it.
    task automatic start_run(input vec_t v);
        a = v.a; b = v.b; c = v.c; k = v.k; mode = v.mode;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        scramble();
    endtask

    // Counts edges including the sampling one; a Start pulse during Busy must be ignored.
    task automatic wait_done(input string name);
        int lat;
        bit seen;
        lat = 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge Clk); #1;
            lat++;
            if (lat == 2) check({name, "_busy"}, {31'b0, Busy}, 1);
            if (lat == 3) begin
                Start = 1'b1; a = 1000; b = -7; c = 42; k = 5; mode = 2'd0;
            end
            if (lat == 4) Start = 1'b0;
            if (Done) seen = 1'b1;
        end
        check({name, "_latency"}, seen ? lat : 0, 8);
    endtask

    task automatic check_results(input string name, input vec_t v);
        check({name, "_x"}, x, v.ex);
        check({name, "_y"}, y, v.ey);
        check({name, "_z"}, z, v.ez);
    endtask

    initial begin
        vecs[0] = mk(5, 3, 1, 1, 2'd0, 6, 7, 1);
        vecs[1] = mk(5, 3, 1, 1, 2'd2, 4, 8, 1);
        vecs[2] = mk(4, 2, 2, 2, 2'd3, 32, 12, 2);
        vecs[3] = mk(-8, -8, 0, 1, 2'd1, -16, -24, -4);
`ifdef HLSM_BRANCH_SAT_EN
        vecs[4] = mk(32'h7FFF_FFFF, 1, 0, 0, 2'd0, 32'h7FFF_FFFE, 32'h7FFF_FFFF, 32'h7FFF_FFFE);
`else
        vecs[4] = mk(32'h7FFF_FFFF, 1, 0, 0, 2'd0, 32'h7FFF_FFFE, 32'h8000_0000, 32'h7FFF_FFFE);
`endif
        vecs[5] = mk(10, 20, -5, 3, 2'd1, -80, 30, -2);
        vecs[6] = mk(1, 2, 3, 4, 2'd0, -16, 3, -1);
        vecs[7] = mk(5, 5, 1, -1, 2'd3, 32'h8000_0000, 5, -1);

        Rst = 1'b1; Start = 1'b0; a = 0; b = 0; c = 0; k = 0; mode = 2'd0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_busy", {31'b0, Busy}, 0);
        check("rst_done", {31'b0, Done}, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_z", z, 0);
        Rst = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 8; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            start_run(vecs[i]);
            wait_done(nm);
            check_results(nm, vecs[i]);
            @(posedge Clk); #1;
            check({nm, "_done_oneshot"}, {31'b0, Done}, 0);
            check({nm, "_idle_after"}, {31'b0, Busy}, 0);
        end

        // Back-to-back: Start asserted in the Done cycle launches the next run.
        start_run(vecs[0]);
        wait_done("b2b_first");
        check_results("b2b_first", vecs[0]);
        start_run(vecs[2]);
        check("b2b_done_drops", {31'b0, Done}, 0);
        check("b2b_busy", {31'b0, Busy}, 1);
        wait_done("b2b_second");
        check_results("b2b_second", vecs[2]);

        // Results hold while idle and inputs move.
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            a = i * 17; b = -i; c = i; k = i; mode = i[1:0];
        end
        check_results("hold", vecs[2]);

        // Reset in S3 aborts the run; Start is accepted on the first edge after reset.
        start_run(vecs[1]);
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk); #1;
        check("abort_done", {31'b0, Done}, 0);
        check("abort_busy", {31'b0, Busy}, 0);
        check("abort_x", x, 0);
        check("abort_y", y, 0);
        check("abort_z", z, 0);
        Rst = 1'b0;
        start_run(vecs[3]);
        wait_done("after_abort");
        check_results("after_abort", vecs[3]);
        @(posedge Clk); #1;
        check("after_abort_idle", {31'b0, Busy}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
